// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns architectural HI/LO.
// Build option: define MDU_DELAY_EN for multi-cycle latency; undefined commits HI/LO in one cycle.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
    $error("mult_div_unit: MULT_CYCLES and DIV_CYCLES must be >= 1");
  end

  md_op_e      op;
  logic        is_arith;
  logic        is_mult;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] res_hi_c;
  logic [31:0] res_lo_c;

  assign op = md_op_e'(md_op);

  // Result defaults to the current HI/LO so a zero divisor leaves them unchanged.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_arith = 1'b0;
    is_mult  = 1'b0;
    prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
    res_hi_c = hi;
    res_lo_c = lo;
    case (op)
      OP_MULT: begin
        is_arith = 1'b1;
        is_mult  = 1'b1;
        {res_hi_c, res_lo_c} = prod_s;
      end
      OP_MULTU: begin
        is_arith = 1'b1;
        is_mult  = 1'b1;
        {res_hi_c, res_lo_c} = prod_u;
      end
      OP_DIV: begin
        is_arith = 1'b1;
        if (rt_val == 32'h0) begin
          res_hi_c = hi;
        end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
          // Overflow case has no representable quotient; wrap as the ISA defines.
          res_lo_c = 32'h8000_0000;
          res_hi_c = 32'h0;
        end else begin
          res_lo_c = 32'($signed(rs_val) / $signed(rt_val));
          res_hi_c = 32'($signed(rs_val) % $signed(rt_val));
        end
      end
      OP_DIVU: begin
        is_arith = 1'b1;
        if (rt_val != 32'h0) begin
          res_lo_c = rs_val / rt_val;
          res_hi_c = rs_val % rt_val;
        end
      end
      default: ;
    endcase
  end

`ifdef MDU_DELAY_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= 32'h0;
      lo     <= 32'h0;
      res_hi <= 32'h0;
      res_lo <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_arith) begin
              res_hi <= res_hi_c;
              res_lo <= res_lo_c;
              cnt    <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state  <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          // start is never asserted here; the hazard unit holds md-class ops in D.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (start) begin
      if (is_arith) begin
        hi <= res_hi_c;
        lo <= res_lo_c;
      end else if (op == OP_MTHI) begin
        hi <= rs_val;
      end else if (op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expectations follow MDU_DELAY_EN.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

`ifdef MDU_DELAY_EN
  localparam int EXP_MC = 5;
  localparam int EXP_DC = 10;
`else
  localparam int EXP_MC = 0;
  localparam int EXP_DC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  ever_busy = 1'b0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy === 1'b1) ever_busy = 1'b1;

  always @(posedge clk) begin
    if (reset === 1'b0 && start === 1'b1)
      assert (busy !== 1'b1) else $error("start asserted while busy");
  end

  // Drive one op for a single edge, then scramble operands to prove they were captured.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    md_op  = OP_NONE;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'h0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mult;
    int cyc;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    if (EXP_MC > 0) begin
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mult_hi_hold: got %h expected %h", hi, 32'h0); end
    end
    wait_done(cyc);
    n_checks++; if (cyc != EXP_MC) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected %0d", cyc, EXP_MC); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFEB); end
  endtask

  task automatic test_multu;
    int cyc;
    issue(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    n_checks++; if (cyc != EXP_MC) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected %0d", cyc, EXP_MC); end
    n_checks++; if (hi !== 32'h0000_0006) begin n_fail++; $display("FAIL multu_hi: got %h expected %h", hi, 32'h6); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFF_FFEB); end
  endtask

  task automatic test_div;
    int cyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
    wait_done(cyc);
    n_checks++; if (cyc != EXP_DC) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected %0d", cyc, EXP_DC); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);   // 7 / -2
    wait_done(cyc);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdivisor_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negdivisor_hi: got %h expected %h", hi, 32'h1); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
  endtask

  task automatic test_divu;
    int cyc;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
    wait_done(cyc);
    n_checks++; if (cyc != EXP_DC) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected %0d", cyc, EXP_DC); end
    n_checks++; if (lo !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_lo: got %h expected %h", lo, 32'h0FFF_FFFF); end
    n_checks++; if (hi !== 32'h0000_000F) begin n_fail++; $display("FAIL divu_hi: got %h expected %h", hi, 32'hF); end
  endtask

  task automatic test_div_by_zero;
    int cyc;
    issue(OP_MTHI, 32'h0000_1234, 32'h0);
    n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi: got %h expected %h", hi, 32'h1234); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    issue(OP_MTLO, 32'h0000_5678, 32'h0);
    n_checks++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo: got %h expected %h", lo, 32'h5678); end
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(cyc);
    n_checks++; if (cyc != EXP_DC) begin n_fail++; $display("FAIL divu0_busy_cycles: got %0d expected %0d", cyc, EXP_DC); end
    n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL divu0_hi: got %h expected %h", hi, 32'h1234); end
    n_checks++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL divu0_lo: got %h expected %h", lo, 32'h5678); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc);
    n_checks++; if (cyc != EXP_DC) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d expected %0d", cyc, EXP_DC); end
    n_checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL div0_hilo: got %h expected %h", {hi, lo}, 64'h0000_1234_0000_5678); end
  endtask

  task automatic test_no_effect_ops;
    issue(OP_RSVD, 32'hAAAA_AAAA, 32'h3);
    n_checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL rsvd_hilo: got %h expected %h", {hi, lo}, 64'h0000_1234_0000_5678); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy: got %b expected 0", busy); end
    issue(OP_NONE, 32'hBBBB_BBBB, 32'h3);
    n_checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL none_hilo: got %h expected %h", {hi, lo}, 64'h0000_1234_0000_5678); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    n_checks++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL b2b_multu: got %h expected %h", {hi, lo}, 64'h0000_0001_0000_0000); end
    // MTLO issued in the very cycle busy drops.
    start  = 1'b1;
    md_op  = OP_MTLO;
    rs_val = 32'h0000_CAFE;
    @(negedge clk);
    start  = 1'b0;
    md_op  = OP_NONE;
    n_checks++; if ({hi, lo} !== 64'h0000_0001_0000_CAFE) begin n_fail++; $display("FAIL b2b_mtlo: got %h expected %h", {hi, lo}, 64'h0000_0001_0000_CAFE); end
  endtask

  task automatic test_reset_mid_op;
    issue(OP_MTHI, 32'h0000_1111, 32'h0);
`ifdef MDU_DELAY_EN
    issue(OP_DIV, 32'd7, 32'd2);
    repeat (3) @(negedge clk);   // now in busy cycle 4
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`else
    issue(OP_MULT, 32'd3, 32'd4);
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL nodelay_mult_lo: got %h expected %h", lo, 32'd12); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL nodelay_mult_hi: got %h expected %h", hi, 32'd0); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h expected 0", {hi, lo}); end
    repeat (15) @(negedge clk);
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_no_late_update: got %h expected 0", {hi, lo}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_late: got %b expected 0", busy); end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = OP_NONE;
    rs_val = 32'h0;
    rt_val = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_div_by_zero();
    test_no_effect_ops();
    test_back_to_back();
    test_reset_mid_op();
    n_checks++;
    if (ever_busy !== (EXP_MC != 0)) begin
      n_fail++;
      $display("FAIL busy_ever_seen: got %b expected %b", ever_busy, (EXP_MC != 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit in the E stage of the five-stage pipeline.
- Consumes the md op code and `ismd` class produced by the decoder, plus forwarded operand values.
- Owns the architectural HI/LO registers and supplies them to `mfhi`/`mflo`.
- Raises `busy` so the hazard unit can stall any md-class instruction in D.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: E-stage instruction is valid, not flushed, and `md_op` is non-zero.
- `md_op` input 3: 0 NOT_MD, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOT_MD.
- `rs_val` input 32: forwarded GPR[rs]; multiplicand, dividend, or MTHI/MTLO source.
- `rt_val` input 32: forwarded GPR[rt]; multiplier or divisor.
- `busy` output 1: an operation is in flight.
- `hi` output 32: architectural HI.
- `lo` output 32: architectural LO.

## Operation
- State machine: IDLE and RUN.
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, state=IDLE. Any pending result is discarded.
- In IDLE, `start`=1 is sampled at the rising edge:
  - MULT/MULTU/DIV/DIVU:
    - compute the result from `rs_val`/`rt_val` into internal `res_hi`/`res_lo`;
    - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
    - go to RUN.
  - MTHI: `hi` ← `rs_val` at that edge; stay in IDLE.
  - MTLO: `lo` ← `rs_val` at that edge; stay in IDLE.
  - NOT_MD or 7: no effect.
- In RUN:
  - the counter decrements each edge;
  - on the edge where it reaches 0: `hi`←`res_hi`, `lo`←`res_lo`, go to IDLE.
- `start` in RUN is ignored. The hazard unit guarantees it never happens; the bench checks it with an assertion.
- Arithmetic:
  - MULT: signed 32×32 → 64-bit product; {HI,LO} = product.
  - MULTU: same as MULT, unsigned.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned. LO = quotient, HI = remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0, DIV or DIVU: the unit still goes busy for `DIV_CYCLES`; HI and LO are left unchanged at completion.
- `busy` is a registered state decode: 1 exactly when state=RUN.

## Timing
- Cycle numbering: start sampled at edge t.
  - `busy`=1 from just after edge t through edge t+N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy` falls, and `hi`/`lo` update, at edge t+N.
  - New `hi`/`lo` are readable by the `mfhi`/`mflo` that stalled behind the op, in the cycle after edge t+N.
- MTHI/MTLO take 1 cycle: the new value is visible right after edge t, with no busy.
- The stall condition seen by the hazard unit is `ismd`(D) & (`start` | `busy`). `busy` alone is insufficient in cycle t, so `start` must be ORed in externally.
- Operands are captured at edge t. Changes on `rs_val`/`rt_val` during RUN have no effect.
- `reset` asserted at any edge during RUN: next cycle IDLE, `busy`=0, `hi`=`lo`=0, and the pending result is lost.
- N must be ≥1. With N=1, `busy` is high for exactly one cycle.

## Configuration
- `MDU_DELAY_EN` defined:
  - latency behaves as above;
  - `busy` is driven by RUN.
- `MDU_DELAY_EN` undefined:
  - RUN is not compiled;
  - MULT/MULTU/DIV/DIVU commit `hi`/`lo` at edge t, the same edge as MTHI/MTLO;
  - `busy` is tied to 0;
  - the parameters are ignored.
  - Arithmetic and divide-by-zero rules are unchanged.

## Test plan
- Reset:
  - Stimulus: hold `reset` 2 cycles.
  - Required: `hi`=`lo`=0 and `busy`=0.
- MULT -3 × 7:
  - Stimulus: `rs_val`=0xFFFFFFFD, `rt_val`=7.
  - Required: `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU with the same operands:
  - Required: HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7 / 2:
  - Required: `busy` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 after MTHI 0x1234 and MTLO 0x5678:
  - Required: after 10 busy cycles, HI=0x1234 and LO=0x5678.
- Reset mid-op:
  - Stimulus: DIV started; assert `reset` at busy cycle 4.
  - Required: `busy`=0 and `hi`=`lo`=0 next cycle; no later update.
  - Repeat with `MDU_DELAY_EN` undefined: MULT 3×4 gives LO=12 one edge after `start`, and `busy` is never 1.
